// File: rtl/error_sample_feeder.sv
// -----------------------------------------------------------------------------
// error_sample_feeder
//
// Producer side of the error-checker handshake. Each sample is read from the
// sample RAM, presented to the error checker on x_bus/y_bus, and the error the
// checker returns is written to the result memory at the sample's index.
// While results are written, two statistics are kept: the largest absolute
// error seen, and how many samples had an absolute error above a threshold.
// A watchdog abandons the run if the checker does not answer within TIMEOUT
// cycles of a request.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   start                 one-cycle run request, honoured only in IDLE
//   n_samples, threshold  run length and |error| limit, captured on start
//   mem_rd, mem_addr      sample RAM read strobe / address
//   mem_x, mem_y          sample RAM data, valid the cycle after mem_rd
//   x_bus, y_bus          data point presented to the error checker
//   en                    one-cycle request to the error checker
//   error_checker_ready   checker can take a request
//   error_checker_done    one-cycle pulse, error_bus valid with it
//   error_bus             signed error from the checker
//   err_wr, err_addr,     result memory write port
//   err_data
//   busy, done            run in progress / one-cycle completion pulse
//   timeout_flag          sticky watchdog abort indication
//   max_abs_err           largest |error| of the current/last run
//   over_count            samples with |error| > threshold
//
// State table
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   S_IDLE      | waiting for start; results of last run held
//   S_FETCH     | read strobe to sample RAM at the current index
//   S_LOAD      | sample RAM data registered onto x_bus/y_bus
//   S_WAIT_RDY  | waiting for the checker to be ready
//   S_ISSUE     | en pulse to checker, watchdog cleared
//   S_WAIT_DONE | waiting for the checker result, watchdog running
//   S_STORE     | result written, statistics updated, index advanced
//   S_FINISH    | done pulse, back to idle
// -----------------------------------------------------------------------------
module error_sample_feeder #(
  parameter int DATA_W  = 20,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_samples,
  input  logic [DATA_W-1:0] threshold,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_x,
  input  logic [DATA_W-1:0] mem_y,
  output logic [DATA_W-1:0] x_bus,
  output logic [DATA_W-1:0] y_bus,
  output logic              en,
  input  logic              error_checker_ready,
  input  logic              error_checker_done,
  input  logic [DATA_W-1:0] error_bus,
  output logic              err_wr,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic              busy,
  output logic              done,
  output logic              timeout_flag,
  output logic [DATA_W-1:0] max_abs_err,
  output logic [ADDR_W-1:0] over_count
);

  localparam int                WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_RDY,
    S_ISSUE,
    S_WAIT_DONE,
    S_STORE,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [ADDR_W-1:0] n_q,     n_d;
  logic [DATA_W-1:0] thr_q,   thr_d;
  logic [DATA_W-1:0] x_q,     x_d;
  logic [DATA_W-1:0] y_q,     y_d;
  logic [DATA_W-1:0] err_q,   err_d;
  logic [WD_W-1:0]   wd_q,    wd_d;
  logic              tmo_q,   tmo_d;
  logic [DATA_W-1:0] max_q,   max_d;
  logic [ADDR_W-1:0] over_q,  over_d;

  logic [WD_W-1:0]   wd_inc;
  logic [DATA_W-1:0] mag;

  // Magnitude of a signed error. Negating the most negative value would wrap
  // back to itself, so it is clamped to the largest positive value instead.
  function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] e);
    logic [DATA_W-1:0] neg;
    neg = ~e + 1'b1;
    if (!e[DATA_W-1]) begin
      return e;
    end else if (e == MOST_NEG) begin
      return MOST_POS;
    end else begin
      return neg;
    end
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      thr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      max_q   <= '0;
      over_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      thr_q   <= thr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      max_q   <= max_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    thr_d   = thr_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    max_d   = max_q;
    over_d  = over_q;
    wd_inc  = wd_q + 1'b1;
    mag     = abs_mag(err_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = n_samples;
          thr_d  = threshold;
          idx_d  = '0;
          max_d  = '0;
          over_d = '0;
          tmo_d  = 1'b0;
          state_d = (n_samples == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        x_d     = mem_x;
        y_d     = mem_y;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (error_checker_ready) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A result arriving on the last watchdog cycle still wins over abort.
        if (error_checker_done) begin
          err_d   = error_bus;
          state_d = S_STORE;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WD_LIMIT) begin
            tmo_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_STORE: begin
        if (mag > max_q) begin
          max_d = mag;
        end
        // Bounded by n_samples, so this counter never wraps.
        if (mag > thr_q) begin
          over_d = over_q + 1'b1;
        end
        if (idx_q == n_q - 1'b1) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_rd       = (state_q == S_FETCH);
  assign mem_addr     = idx_q;
  assign x_bus        = x_q;
  assign y_bus        = y_q;
  assign en           = (state_q == S_ISSUE);
  assign err_wr       = (state_q == S_STORE);
  assign err_addr     = idx_q;
  assign err_data     = err_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done         = (state_q == S_FINISH);
  assign timeout_flag = tmo_q;
  assign max_abs_err  = max_q;
  assign over_count   = over_q;

endmodule

// File: tb/tb_error_sample_feeder.sv
module tb_error_sample_feeder;
  localparam int DW = 20;
  localparam int AW = 10;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] n_samples;
  logic [DW-1:0] threshold;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_x;
  logic [DW-1:0] mem_y;
  logic [DW-1:0] x_bus;
  logic [DW-1:0] y_bus;
  logic          en;
  logic          error_checker_ready;
  logic          error_checker_done;
  logic [DW-1:0] error_bus;
  logic          err_wr;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
  logic          busy;
  logic          done;
  logic          timeout_flag;
  logic [DW-1:0] max_abs_err;
  logic [AW-1:0] over_count;

  error_sample_feeder #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .threshold(threshold), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .x_bus(x_bus), .y_bus(y_bus), .en(en),
    .error_checker_ready(error_checker_ready),
    .error_checker_done(error_checker_done), .error_bus(error_bus),
    .err_wr(err_wr), .err_addr(err_addr), .err_data(err_data), .busy(busy),
    .done(done), .timeout_flag(timeout_flag), .max_abs_err(max_abs_err),
    .over_count(over_count)
  );

  always #5 clk = ~clk;

  // Sample memory, forced checker results and the expected error per sample.
  logic [DW-1:0] mx [0:1023];
  logic [DW-1:0] my [0:1023];
  logic [DW-1:0] ferr [0:1023];
  logic [DW-1:0] experr [0:1023];

  // Checker behaviour: mode 0 returns y-x, mode 1 returns ferr[x], mode 2 never answers.
  int ch_mode = 0;
  int ch_lat  = 1;
  logic rdy_force = 1'b1;
  logic rdy_rand  = 1'b0;
  logic rdy_rnd   = 1'b1;

  logic [DW-1:0] mem_x_r = '0;
  logic [DW-1:0] mem_y_r = '0;
  logic          chk_done_r = 1'b0;
  logic [DW-1:0] err_bus_r = '0;
  logic [DW-1:0] perr = '0;
  int            pend = 0;

  assign mem_x = mem_x_r;
  assign mem_y = mem_y_r;
  assign error_checker_done  = chk_done_r;
  assign error_bus           = err_bus_r;
  assign error_checker_ready = rdy_rand ? rdy_rnd : rdy_force;

  function automatic logic [DW-1:0] chk_val();
    if (ch_mode == 1) return ferr[x_bus[AW-1:0]];
    return y_bus - x_bus;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_x_r <= mx[mem_addr];
      mem_y_r <= my[mem_addr];
    end
  end

  always @(posedge clk) begin
    chk_done_r <= 1'b0;
    if (pend == 1) begin
      chk_done_r <= 1'b1;
      err_bus_r  <= perr;
    end
    if (pend != 0) pend <= pend - 1;
    if (en && ch_mode != 2) begin
      if (ch_lat <= 1) begin
        chk_done_r <= 1'b1;
        err_bus_r  <= chk_val();
      end else begin
        pend <= ch_lat - 1;
        perr <= chk_val();
      end
    end
  end

  always @(negedge clk) rdy_rnd <= ($urandom_range(0, 2) != 0);

  // Observation of DUT activity.
  int cyc = 0;
  int en_cnt = 0, rd_cnt = 0, done_cnt = 0, en_cyc = 0, done_cyc = 0;
  logic [AW-1:0] wq_a [$];
  logic [DW-1:0] wq_d [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err_wr) begin
      wq_a.push_back(err_addr);
      wq_d.push_back(err_data);
    end
    if (en) begin
      en_cnt <= en_cnt + 1;
      en_cyc <= cyc;
    end
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One run from start to done, checked against statistics computed directly
  // from the expected per-sample errors.
  task automatic do_run(input string tag, input int n, input int thr, input bit poke,
                        output int span);
    int emax, eover, e, mag, w0, d0, k, nw;
    emax = 0;
    eover = 0;
    for (int i = 0; i < n; i++) begin
      e = int'($signed(experr[i]));
      mag = (e < 0) ? -e : e;
      if (mag > 524287) mag = 524287;
      if (mag > emax) emax = mag;
      if (mag > thr) eover++;
    end
    w0 = wq_a.size();
    d0 = done_cnt;
    start = 1'b1;
    n_samples = AW'(n);
    threshold = DW'(thr);
    step();
    start = 1'b0;
    n_samples = AW'($urandom);
    threshold = DW'($urandom);
    span = 1;
    if (poke) begin
      step();
      step();
      start = 1'b1;
      n_samples = AW'(1);
      threshold = '0;
      step();
      start = 1'b0;
      span += 3;
    end
    k = 0;
    while (!done && k < 20000) begin
      step();
      k++;
    end
    span += k;
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
    check({tag, " max"}, max_abs_err, emax);
    check({tag, " over"}, over_count, eover);
    check({tag, " timeout"}, {31'b0, timeout_flag}, 32'd0);
    step();
    nw = wq_a.size() - w0;
    check({tag, " nwrites"}, nw, n);
    for (int i = 0; i < n && i < nw; i++) begin
      check({tag, " waddr"}, wq_a[w0 + i], i);
      check({tag, " wdata"}, wq_d[w0 + i], experr[i]);
    end
    check({tag, " done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: observed hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int span, e0, w0, d0, r0, k, n, thr;
    rst = 1'b0;
    start = 1'b0;
    n_samples = '0;
    threshold = '0;
    for (int i = 0; i < 1024; i++) begin
      mx[i] = '0; my[i] = '0; ferr[i] = '0; experr[i] = '0;
    end
    repeat (3) step();

    // Reset state.
    check("rst busy", {31'b0, busy}, 0);
    check("rst done", {31'b0, done}, 0);
    check("rst en", {31'b0, en}, 0);
    check("rst mem_rd", {31'b0, mem_rd}, 0);
    check("rst err_wr", {31'b0, err_wr}, 0);
    check("rst timeout", {31'b0, timeout_flag}, 0);
    check("rst max", max_abs_err, 0);
    check("rst over", over_count, 0);
    check("rst x_bus", x_bus, 0);
    check("rst mem_addr", mem_addr, 0);
    rst = 1'b1;
    step();

    // Basic run: checker echoes y-x one cycle after en, 6 cycles per sample.
    for (int i = 0; i < 3; i++) begin
      mx[i] = DW'(i + 1);
      my[i] = DW'(i + 4);
      experr[i] = my[i] - mx[i];
    end
    ch_mode = 0; ch_lat = 1;
    do_run("basic", 3, 2, 1'b0, span);
    check("basic max3", max_abs_err, 3);
    check("basic over3", over_count, 3);
    check("basic latency", span, 19);

    // Signed errors, tie on max, strict threshold.
    for (int i = 0; i < 4; i++) mx[i] = DW'(i);
    ferr[0] = -DW'(7); ferr[1] = DW'(5); ferr[2] = DW'(7);
    for (int i = 0; i < 3; i++) experr[i] = ferr[i];
    ch_mode = 1;
    do_run("signed", 3, 6, 1'b0, span);
    check("signed max7", max_abs_err, 7);
    check("signed over2", over_count, 2);

    // Most negative error saturates; threshold equal to magnitude is not over.
    ferr[0] = 20'h80000; ferr[1] = 20'h7FFFF;
    experr[0] = ferr[0]; experr[1] = ferr[1];
    do_run("satur_eq", 2, 32'h7FFFF, 1'b0, span);
    do_run("satur_gt", 1, 32'h7FFFE, 1'b0, span);
    check("satur max", max_abs_err, 32'h7FFFF);

    // Checker not ready for 10 cycles: no en, data held.
    ch_mode = 0;
    mx[0] = 20'd11; my[0] = 20'd30;
    rdy_force = 1'b0;
    w0 = wq_a.size();
    start = 1'b1; n_samples = AW'(1); threshold = '0;
    step();
    start = 1'b0;
    check("rdy busy", {31'b0, busy}, 1);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check("rdy en_low", {31'b0, en}, 0);
      check("rdy x_hold", x_bus, 11);
      check("rdy y_hold", y_bus, 30);
      step();
    end
    rdy_force = 1'b1;
    step();
    check("rdy en_next", {31'b0, en}, 1);
    check("rdy x_at_en", x_bus, 11);
    k = 0;
    while (!done && k < 100) begin step(); k++; end
    check("rdy done", {31'b0, done}, 1);
    check("rdy max", max_abs_err, 19);
    check("rdy over", over_count, 1);
    step();
    check("rdy nwrites", wq_a.size() - w0, 1);
    if (wq_a.size() > w0) check("rdy wdata", wq_d[w0], 19);

    // Checker never answers: watchdog abort.
    ch_mode = 2;
    e0 = en_cnt; w0 = wq_a.size();
    start = 1'b1; n_samples = AW'(2); threshold = '0;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 300) begin step(); k++; end
    check("tmo done", {31'b0, done}, 1);
    check("tmo flag", {31'b0, timeout_flag}, 1);
    check("tmo delay", done_cyc - en_cyc, TO + 1);
    check("tmo en_once", en_cnt - e0, 1);
    step();
    check("tmo nwrites", wq_a.size() - w0, 0);
    check("tmo sticky", {31'b0, timeout_flag}, 1);

    // Zero-length run also clears the sticky timeout flag.
    ch_mode = 0;
    e0 = en_cnt; r0 = rd_cnt;
    do_run("zero", 0, 5, 1'b0, span);
    check("zero latency", span, 1);
    check("zero no_en", en_cnt - e0, 0);
    check("zero no_rd", rd_cnt - r0, 0);

    // Randomized runs; one also pulses start while busy.
    rdy_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      thr = $urandom_range(0, 524287);
      ch_lat = $urandom_range(1, 4);
      ch_mode = r % 2;
      for (int i = 0; i < n; i++) begin
        if (ch_mode == 1) begin
          mx[i] = DW'(i);
          ferr[i] = ($urandom_range(0, 4) == 0) ? 20'h80000 : DW'($urandom);
          experr[i] = ferr[i];
        end else begin
          mx[i] = DW'($urandom);
          my[i] = DW'($urandom);
          experr[i] = my[i] - mx[i];
        end
      end
      do_run("random", n, thr, (r == 2), span);
    end
    rdy_rand = 1'b0;
    rdy_force = 1'b1;

    // Reset in WAIT_DONE of sample 1; the late checker result must be ignored.
    ch_mode = 0; ch_lat = 8;
    mx[0] = 20'd5; my[0] = 20'd1; mx[1] = 20'd6; my[1] = 20'd100;
    mx[2] = 20'd7; my[2] = 20'd200;
    e0 = en_cnt; w0 = wq_a.size(); d0 = done_cnt;
    start = 1'b1; n_samples = AW'(3); threshold = '0;
    step();
    start = 1'b0;
    k = 0;
    while (en_cnt < e0 + 2 && k < 200) begin step(); k++; end
    check("mid reached_s1", en_cnt - e0, 2);
    step();
    step();
    check("mid pre_max", max_abs_err, 4);
    #2;
    rst = 1'b0;
    #1;
    check("mid busy", {31'b0, busy}, 0);
    check("mid en", {31'b0, en}, 0);
    check("mid err_wr", {31'b0, err_wr}, 0);
    check("mid x_bus", x_bus, 0);
    check("mid y_bus", y_bus, 0);
    check("mid max", max_abs_err, 0);
    check("mid over", over_count, 0);
    check("mid mem_addr", mem_addr, 0);
    check("mid err_data", err_data, 0);
    step();
    step();
    rst = 1'b1;
    repeat (10) step();
    check("mid nwrites", wq_a.size() - w0, 1);
    check("mid no_done", done_cnt - d0, 0);
    check("mid idle", {31'b0, busy}, 0);
    check("mid max_after", max_abs_err, 0);
    check("mid en_after", en_cnt - e0, 2);
    ch_lat = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
